// File: rtl/ghr_index_unit.sv
// Global-history front end for a gshare predictor: speculative/committed GHR pair, PHT index and F->D->E prediction pipe.
// Optional feature: define GHR_GSHARE_XOR_EN to XOR the fetch PC into the PHT index; otherwise the index is the GHR alone.
`timescale 1ns/1ps
module ghr_index_unit #(
  parameter int NUM_GHR_BITS = 5,
  parameter int PC_BITS      = 32
) (
  input  logic                    clk,
  input  logic                    reset_ni,
  input  logic [PC_BITS-1:0]      pc_f_i,
  input  logic                    branch_f_i,
  input  logic                    predict_taken_i,
  input  logic                    B_e_i,
  input  logic                    taken_e_i,
  output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
  output logic                    PHTincrement_o,
  output logic                    B_o,
  output logic                    predict_taken_o,
  output logic                    mispredict_o,
  output logic [NUM_GHR_BITS-1:0] ghr_o
);

  logic [NUM_GHR_BITS-1:0] spec_ghr_q, spec_ghr_d;
  logic [NUM_GHR_BITS-1:0] commit_ghr_q, commit_ghr_d;
  logic                    valid_d_q, valid_d_d;
  logic                    valid_e_q, valid_e_d;
  logic                    pred_d_q, pred_d_d;
  logic                    pred_e_q, pred_e_d;
  logic                    b_upd;
  logic                    mispredict;
  logic                    predict_taken;
  logic                    unused_pc;

  assign unused_pc = ^pc_f_i;

  always_comb begin
    // Fetch-side and increment outputs are gated so they read 0 while reset is held.
    predict_taken = reset_ni & branch_f_i & predict_taken_i;
    b_upd         = B_e_i & valid_e_q;
    mispredict    = b_upd & (pred_e_q != taken_e_i);

    spec_ghr_d   = spec_ghr_q;
    commit_ghr_d = commit_ghr_q;
    if (mispredict) begin
      spec_ghr_d = {commit_ghr_q[NUM_GHR_BITS-2:0], taken_e_i};
    end else if (branch_f_i) begin
      spec_ghr_d = {spec_ghr_q[NUM_GHR_BITS-2:0], predict_taken_i};
    end
    if (b_upd) begin
      commit_ghr_d = {commit_ghr_q[NUM_GHR_BITS-2:0], taken_e_i};
    end

    valid_d_d = branch_f_i & ~mispredict;
    pred_d_d  = predict_taken;
    valid_e_d = valid_d_q & ~mispredict;
    pred_e_d  = pred_d_q;
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
      valid_d_q    <= 1'b0;
      valid_e_q    <= 1'b0;
      pred_d_q     <= 1'b0;
      pred_e_q     <= 1'b0;
    end else begin
      spec_ghr_q   <= spec_ghr_d;
      commit_ghr_q <= commit_ghr_d;
      valid_d_q    <= valid_d_d;
      valid_e_q    <= valid_e_d;
      pred_d_q     <= pred_d_d;
      pred_e_q     <= pred_e_d;
    end
  end

`ifdef GHR_GSHARE_XOR_EN
  assign PHTreadaddress_o = spec_ghr_q ^ pc_f_i[NUM_GHR_BITS+1:2];
`else
  assign PHTreadaddress_o = spec_ghr_q;
`endif

  assign PHTincrement_o  = reset_ni & taken_e_i;
  assign B_o             = b_upd;
  assign predict_taken_o = predict_taken;
  assign mispredict_o    = mispredict;
  assign ghr_o           = spec_ghr_q;

endmodule

// File: tb/tb_ghr_index_unit.sv
// Directed bench for ghr_index_unit (N=5); index expectations follow GHR_GSHARE_XOR_EN as compiled.
`timescale 1ns/1ps
module tb_ghr_index_unit;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [31:0] pc_f_i;
  logic        branch_f_i, predict_taken_i, B_e_i, taken_e_i;
  logic [4:0]  PHTreadaddress_o, ghr_o;
  logic        PHTincrement_o, B_o, predict_taken_o, mispredict_o;

  int n_cmp = 0;
  int n_mis = 0;

  ghr_index_unit #(.NUM_GHR_BITS(5), .PC_BITS(32)) dut (
    .clk(clk), .reset_ni(reset_ni), .pc_f_i(pc_f_i),
    .branch_f_i(branch_f_i), .predict_taken_i(predict_taken_i),
    .B_e_i(B_e_i), .taken_e_i(taken_e_i),
    .PHTreadaddress_o(PHTreadaddress_o), .PHTincrement_o(PHTincrement_o),
    .B_o(B_o), .predict_taken_o(predict_taken_o),
    .mispredict_o(mispredict_o), .ghr_o(ghr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic pt, input logic be, input logic tk);
    branch_f_i = br; predict_taken_i = pt; B_e_i = be; taken_e_i = tk;
    #1;
  endtask

  function automatic logic [4:0] exp_idx(input logic [4:0] ghr, input logic [31:0] pc);
`ifdef GHR_GSHARE_XOR_EN
    exp_idx = ghr ^ pc[6:2];
`else
    exp_idx = ghr;
`endif
  endfunction

  initial begin
    // Reset held with live inputs
    reset_ni = 1'b0; pc_f_i = 32'h7C;
    drive(1, 1, 1, 1);
    check("rst_b", {31'd0, B_o}, 0);
    check("rst_mis", {31'd0, mispredict_o}, 0);
    check("rst_ghr", {27'd0, ghr_o}, 0);
    check("rst_pt", {31'd0, predict_taken_o}, 0);
    check("rst_inc", {31'd0, PHTincrement_o}, 0);
    check("rst_idx_7c", {27'd0, PHTreadaddress_o}, {27'd0, exp_idx(5'b00000, 32'h7C)});
    tick();
    pc_f_i = 32'h14;
    drive(0, 1, 1, 0);
    check("rst_idx_14", {27'd0, PHTreadaddress_o}, {27'd0, exp_idx(5'b00000, 32'h14)});
    check("rst_ghr2", {27'd0, ghr_o}, 0);

    // Release away from the edge; speculative shift 1,1,0
    pc_f_i = 32'h0;
    drive(0, 0, 0, 0);
    reset_ni = 1'b1;
    drive(1, 1, 0, 0);
    check("a_pt", {31'd0, predict_taken_o}, 1);
    tick();
    check("a_ghr", {27'd0, ghr_o}, 32'b00001);
    drive(1, 1, 1, 1);
    check("b_empty_e", {31'd0, B_o}, 0);
    tick();
    check("b_ghr", {27'd0, ghr_o}, 32'b00011);
    drive(1, 0, 1, 1);
    check("c_pt0", {31'd0, predict_taken_o}, 0);
    check("c_b", {31'd0, B_o}, 1);
    check("c_inc", {31'd0, PHTincrement_o}, 1);
    check("c_mis", {31'd0, mispredict_o}, 0);
    tick();
    check("c_ghr", {27'd0, ghr_o}, 32'b00110);
    drive(0, 0, 1, 1);
    check("d_b", {31'd0, B_o}, 1);
    check("d_mis", {31'd0, mispredict_o}, 0);
    tick();
    drive(0, 0, 1, 0);
    check("e_b", {31'd0, B_o}, 1);
    check("e_inc", {31'd0, PHTincrement_o}, 0);
    check("e_mis", {31'd0, mispredict_o}, 0);
    tick();
    check("e_ghr", {27'd0, ghr_o}, 32'b00110);
    drive(0, 0, 1, 1);
    check("f_drained", {31'd0, B_o}, 0);
    tick();

    // Fresh reset mid-run, then 3 taken predictions and a not-taken resolve
    reset_ni = 1'b0;
    drive(0, 0, 0, 0);
    check("rst2_ghr", {27'd0, ghr_o}, 0);
    reset_ni = 1'b1;
    drive(1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    tick();
    check("g2_ghr", {27'd0, ghr_o}, 32'b00011);
    drive(1, 1, 1, 0);
    check("g3_mis", {31'd0, mispredict_o}, 1);
    check("g3_b", {31'd0, B_o}, 1);
    check("g3_pt", {31'd0, predict_taken_o}, 1);
    tick();
    check("g3_ghr_restored", {27'd0, ghr_o}, 32'b00000);
    drive(0, 0, 1, 1);
    check("g4_flushed_d", {31'd0, B_o}, 0);
    check("g4_mis", {31'd0, mispredict_o}, 0);
    tick();
    drive(0, 0, 1, 1);
    check("g5_dropped_f", {31'd0, B_o}, 0);
    tick();

    // Mispredict with taken outcome, simultaneous fetch branch
    drive(1, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    tick();
    check("h2_ghr", {27'd0, ghr_o}, 32'b00001);
    drive(1, 1, 1, 1);
    check("h3_mis", {31'd0, mispredict_o}, 1);
    check("h3_inc", {31'd0, PHTincrement_o}, 1);
    tick();
    check("h3_ghr_restored", {27'd0, ghr_o}, 32'b00001);
    drive(0, 0, 1, 1);
    check("h4_flushed_d", {31'd0, B_o}, 0);
    tick();
    drive(0, 0, 1, 1);
    check("h5_dropped_f", {31'd0, B_o}, 0);
    tick();
    check("h5_ghr", {27'd0, ghr_o}, 32'b00001);

    // Build 01010, then index with various PCs
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    pc_f_i = 32'h7C;
    drive(0, 0, 0, 0);
    check("i_ghr", {27'd0, ghr_o}, 32'b01010);
    check("i_idx_7c", {27'd0, PHTreadaddress_o}, {27'd0, exp_idx(5'b01010, 32'h7C)});
    pc_f_i = 32'h14; #1;
    check("i_idx_14", {27'd0, PHTreadaddress_o}, {27'd0, exp_idx(5'b01010, 32'h14)});
    pc_f_i = 32'hFFFF_FF83; #1;
    check("i_idx_hi", {27'd0, PHTreadaddress_o}, 32'b01010);

    // MSB discarded on shift
    drive(1, 1, 0, 0); tick();
    check("w1_ghr", {27'd0, ghr_o}, 32'b10101);
    drive(1, 1, 0, 0); tick();
    check("w2_ghr", {27'd0, ghr_o}, 32'b01011);
    drive(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
